// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide producing the HI/LO register pair.
//
// Multiply is radix-2 shift-add on operand magnitudes. Divide is restoring
// division on operand magnitudes. Both take one bit per clock. The signs are
// applied in a final FIX cycle, so both datapaths only handle unsigned values.
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - synchronous, active-low
//   start     - request an operation; honoured only when idle
//   op        - 00 mult, 01 multu, 10 div, 11 divu
//   a, b      - operands, captured on the accepting edge
//   busy      - operation in progress
//   done      - one-cycle pulse; hi/lo/div_zero valid from this cycle on
//   div_zero  - last completed divide had a zero divisor
//   hi, lo    - product upper/lower half, or remainder/quotient
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZDIV} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               is_mul;
    logic               neg_a;
    logic               neg_b;
    // Multiply: addend (|a|). Divide: divisor (|b|).
    logic [WIDTH-1:0]   opnd;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half holds the dividend and shifts quotient bits in.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;

    logic             last;
    logic             sgn_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Datapath step values.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     shl;
    logic [WIDTH+1:0]   diff;
    logic               ge;

    // Sign-fixed results.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   remd;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign sgn_in = ~op[0];
    // The negation of the most negative value wraps to itself. Read as
    // unsigned, that is the correct magnitude 2^(WIDTH-1).
    assign abs_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
    assign abs_b  = (sgn_in && b[WIDTH-1]) ? -b : b;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt = {sum, acc[WIDTH-1:1]};
        shl     = {rem[WIDTH-1:0], acc[WIDTH-1]};
        // One extra bit so that the borrow shows whether the trial subtract fits.
        diff    = {1'b0, shl} - {2'b00, opnd};
        ge      = ~diff[WIDTH+1];
    end

    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quot = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remd = neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (op[1] && b == '0) ? ZDIV : RUN;
            RUN:  if (last)  state_nxt = FIX;
            FIX:             state_nxt = IDLE;
            ZDIV:            state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_mul   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            rem      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_mul <= ~op[1];
                        neg_a  <= sgn_in & a[WIDTH-1];
                        neg_b  <= sgn_in & b[WIDTH-1];
                        opnd   <= op[1] ? abs_b : abs_a;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        rem    <= '0;
                    end
                end
                RUN: begin
                    if (is_mul) begin
                        acc <= mul_nxt;
                    end else begin
                        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
                        rem <= ge ? diff[WIDTH:0] : shl;
                    end
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        busy <= 1'b0;
                        cnt  <= '0;
                    end
                end
                FIX: begin
                    if (is_mul) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else begin
                        hi <= remd;
                        lo <= quot;
                    end
                    done     <= 1'b1;
                    div_zero <= 1'b0;
                end
                ZDIV: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: 32-bit and 8-bit instances, a scoreboard fed at
// issue time, and a per-instance monitor that pops on every done pulse.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        start32 = 1'b0, start8 = 1'b0;
    logic [1:0]  op32 = '0, op8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy32, done32, dz32, busy8, done8, dz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int npass = 0;
    int ntotal = 0;

    exp_t q32[$];
    exp_t q8[$];
    logic [31:0] ph32 = '0, pl32 = '0, ph8 = '0, pl8 = '0;
    int nbusy_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on sign- or zero-extended operands.
    function automatic exp_t model(input int w, input logic [1:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic [31:0] ph, input logic [31:0] pl);
        exp_t        e;
        logic [63:0] mask, p;
        longint      sx, sy, q, r;
        mask = (64'd1 << w) - 64'd1;
        sx = longint'({32'd0, x});
        sy = longint'({32'd0, y});
        if (!o[0] && x[w-1]) sx -= (longint'(1) << w);
        if (!o[0] && y[w-1]) sy -= (longint'(1) << w);
        e.cyc = 0;
        if (!o[1]) begin
            p = sx * sy;
            e.lo = 32'(p & mask);
            e.hi = 32'((p >> w) & mask);
            e.dz = 1'b0;
        end else if (y == 32'd0) begin
            e.hi = ph;
            e.lo = pl;
            e.dz = 1'b1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            e.lo = 32'(q & longint'(mask));
            e.hi = 32'(r & longint'(mask));
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Call at a negedge; start goes high for the next rising edge.
    task automatic launch(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        x = x & m;
        y = y & m;
        if (w == 32) begin
            e = model(32, o, x, y, ph32, pl32);
            ph32 = e.hi; pl32 = e.lo;
        end else begin
            e = model(8, o, x, y, ph8, pl8);
            ph8 = e.hi; pl8 = e.lo;
        end
        nbusy_exp = (o[1] && y == 0) ? 1 : w;
        e.cyc = cyc + ((o[1] && y == 0) ? 2 : w + 2);
        if (w == 32) begin
            q32.push_back(e);
            start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        end else begin
            q8.push_back(e);
            start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
        end
    endtask

    // Waits for done, counting busy cycles. If poke > 0, a second start with
    // fresh operands is pulsed on that cycle of the running operation.
    task automatic wait_done(input int w, input int poke);
        int   nb;
        bit   got;
        logic d, bs;
        nb  = 0;
        got = 1'b0;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clock);
            if (w == 32) begin
                start32 = (i == poke);
                if (i == poke) begin a32 = $urandom; b32 = $urandom; end
                d = done32; bs = busy32;
            end else begin
                start8 = (i == poke);
                if (i == poke) begin a8 = 8'($urandom); b8 = 8'($urandom); end
                d = done8; bs = busy8;
            end
            if (d) begin
                got = 1'b1;
                check("busy_in_done_cycle", {63'd0, bs}, 64'd0);
            end else if (bs) begin
                nb++;
            end
        end
        check("done_seen", {63'd0, got}, 64'd1);
        if (got) check("busy_cycles", 64'(nb), 64'(nbusy_exp));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0080;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (done32) begin
            ntotal++;
            if (q32.size() == 0) begin
                $display("FAIL done32_unexpected: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                npass++;
                e = q32.pop_front();
                check("hi32", {32'd0, hi32}, {32'd0, e.hi});
                check("lo32", {32'd0, lo32}, {32'd0, e.lo});
                check("div_zero32", {63'd0, dz32}, {63'd0, e.dz});
                check("done_cycle32", 64'(cyc), 64'(e.cyc));
            end
        end
        if (done8) begin
            ntotal++;
            if (q8.size() == 0) begin
                $display("FAIL done8_unexpected: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                npass++;
                e = q8.pop_front();
                check("hi8", {56'd0, hi8}, {32'd0, e.hi});
                check("lo8", {56'd0, lo8}, {32'd0, e.lo});
                check("div_zero8", {63'd0, dz8}, {63'd0, e.dz});
                check("done_cycle8", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy32", {63'd0, busy32}, 64'd0);
        check("rst_done32", {63'd0, done32}, 64'd0);
        check("rst_dz32", {63'd0, dz32}, 64'd0);
        check("rst_hilo32", {hi32, lo32}, 64'd0);
        check("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed cases, 32-bit.
        launch(32, 2'b00, 32'hFFFF_FFFD, 32'd7);          wait_done(32, 0);
        launch(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done(32, 0);
        launch(32, 2'b10, 32'hFFFF_FFF9, 32'd2);          wait_done(32, 0);
        launch(32, 2'b11, 32'h0000_2211, 32'h100);        wait_done(32, 0);
        launch(32, 2'b11, 32'd7, 32'd0);                  wait_done(32, 0);
        launch(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(32, 0);
        launch(32, 2'b11, 32'h8000_0000, 32'd3);          wait_done(32, 0);
        launch(32, 2'b10, 32'd0, 32'd0);                  wait_done(32, 0);
        launch(32, 2'b00, 32'h1234_5678, 32'h8765_4321);  wait_done(32, 10);

        // Directed cases, 8-bit.
        launch(8, 2'b00, 32'h80, 32'h80);                 wait_done(8, 0);
        launch(8, 2'b10, 32'h81, 32'h10);                 wait_done(8, 0);
        launch(8, 2'b10, 32'h80, 32'hFF);                 wait_done(8, 0);
        launch(8, 2'b10, 32'h05, 32'h00);                 wait_done(8, 3);

        // Randomized, back-to-back.
        for (int k = 0; k < 30; k++) begin
            launch(32, 2'($urandom_range(0, 3)), pick(), pick());
            wait_done(32, 0);
        end
        for (int k = 0; k < 40; k++) begin
            launch(8, 2'($urandom_range(0, 3)), pick(), pick());
            wait_done(8, 0);
        end

        // Reset in the middle of an operation: aborted, cleared, no done.
        launch(32, 2'b00, 32'h0000_0123, 32'h0000_0456);
        @(negedge clock);
        start32 = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", {63'd0, busy32}, 64'd0);
        check("abort_done", {63'd0, done32}, 64'd0);
        check("abort_hilo", {hi32, lo32}, 64'd0);
        check("abort_dz", {63'd0, dz32}, 64'd0);
        q32.delete();
        ph32 = '0; pl32 = '0; ph8 = '0; pl8 = '0;
        reset = 1'b1;
        repeat (70) @(negedge clock);

        // Working again after the abort.
        launch(32, 2'b11, 32'd100, 32'd7);                wait_done(32, 0);

        repeat (3) @(negedge clock);
        check("queue32_empty", 64'(q32.size()), 64'd0);
        check("queue8_empty", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
